// File: rtl/debug_pkg.sv
// Shared definitions for the debug formatters: ASCII constants, the line FSM
// state encoding and the nibble-to-hex mapping.
package debug_pkg;

  localparam logic [7:0] ASCII_C  = 8'h43;
  localparam logic [7:0] ASCII_N  = 8'h4E;
  localparam logic [7:0] ASCII_T  = 8'h54;
  localparam logic [7:0] ASCII_EQ = 8'h3D;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PREFIX = 3'd1,
    DIGITS = 3'd2,
    CR     = 3'd3,
    LF     = 3'd4
  } state_e;

  // Uppercase hex: 0-9 -> '0'..'9', 10-15 -> 'A'..'F'.
  function automatic logic [7:0] nibble_to_hex(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Combinational 4-bit to uppercase ASCII hex digit converter; shared by the
// TX formatter, RX echo and status dumpers.
module hex_nibble_to_ascii
  import debug_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  assign ascii = nibble_to_hex(nibble);

endmodule

// File: rtl/debug_hex_formatter.sv
// Streams "CNT=<hex>\r\n" for a value snapshotted on a trigger rising edge,
// over a valid/ready byte interface feeding the debug UART transmitter.
module debug_hex_formatter
  import debug_pkg::*;
#(
  parameter int VALUE_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   trigger,
  input  logic [VALUE_WIDTH-1:0] value,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic                   dropped
);

  localparam int HEX_DIGITS = VALUE_WIDTH / 4;
  localparam int IDX_W      = $clog2(HEX_DIGITS + 4);

  typedef logic [IDX_W-1:0] idx_t;

  state_e                 state_q, state_d;
  idx_t                   idx_q, idx_d;
  logic [VALUE_WIDTH-1:0] snap_q, snap_d;
  logic                   trig_prev_q;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   tx_valid_q, tx_valid_d;
  logic                   busy_q, busy_d;
  logic                   dropped_q, dropped_d;

  logic                   trig_edge;
  logic                   hs;
  idx_t                   idx_nxt;
  idx_t                   digit_sel;
  logic [VALUE_WIDTH-1:0] digit_word;
  logic [3:0]             digit_nibble;
  logic [7:0]             digit_ascii;

  assign trig_edge = trigger && !trig_prev_q;
  assign hs        = tx_valid_q && tx_ready;
  assign idx_nxt   = idx_q + 1'b1;

  // Digit that will be presented after the current handshake: digit 0 when
  // leaving the prefix, otherwise the one following the current digit.
  assign digit_sel    = (state_q == PREFIX) ? '0 : idx_nxt;
  assign digit_word   = snap_q << {digit_sel, 2'b00};
  assign digit_nibble = digit_word[VALUE_WIDTH-1 -: 4];

  hex_nibble_to_ascii u_hex (
    .nibble (digit_nibble),
    .ascii  (digit_ascii)
  );

  function automatic logic [7:0] prefix_byte(input idx_t i);
    case (i)
      idx_t'(0): return ASCII_C;
      idx_t'(1): return ASCII_N;
      idx_t'(2): return ASCII_T;
      default:   return ASCII_EQ;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    snap_d     = snap_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    dropped_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (trig_edge) begin
          snap_d     = value;
          tx_data_d  = ASCII_C;
          tx_valid_d = 1'b1;
          busy_d     = 1'b1;
          idx_d      = '0;
          state_d    = PREFIX;
        end
      end
      PREFIX: begin
        if (hs) begin
          if (idx_q == idx_t'(3)) begin
            state_d   = DIGITS;
            idx_d     = '0;
            tx_data_d = digit_ascii;
          end else begin
            idx_d     = idx_nxt;
            tx_data_d = prefix_byte(idx_nxt);
          end
        end
      end
      DIGITS: begin
        if (hs) begin
          if (idx_q == idx_t'(HEX_DIGITS - 1)) begin
            state_d   = CR;
            tx_data_d = ASCII_CR;
          end else begin
            idx_d     = idx_nxt;
            tx_data_d = digit_ascii;
          end
        end
      end
      CR: begin
        if (hs) begin
          state_d   = LF;
          tx_data_d = ASCII_LF;
        end
      end
      LF: begin
        if (hs) begin
          // A fresh edge on the final handshake chains straight into a new line.
          if (trig_edge) begin
            snap_d    = value;
            tx_data_d = ASCII_C;
            idx_d     = '0;
            state_d   = PREFIX;
          end else begin
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (trig_edge && (state_q != IDLE) && !((state_q == LF) && hs))
      dropped_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      snap_q      <= '0;
      trig_prev_q <= 1'b1;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      trig_prev_q <= trigger;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      busy_q      <= busy_d;
      dropped_q   <= dropped_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign dropped  = dropped_q;

endmodule

// File: tb/tb_debug_hex_formatter.sv
// Directed bench for debug_hex_formatter: table of values with hand-computed
// digit bytes, plus sequences for stalls, drops, back-to-back lines and reset.
module tb_debug_hex_formatter;

  logic        clk = 1'b0;
  logic        reset;
  logic        trigger;
  logic [23:0] value;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        dropped;

  debug_hex_formatter #(.VALUE_WIDTH(24)) dut (
    .clk      (clk),
    .reset    (reset),
    .trigger  (trigger),
    .value    (value),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .dropped  (dropped)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] got_q[$];
  int         dropped_cnt, busy_cnt, valid_cnt, stab_err;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  // Observer: records accepted bytes and checks hold-while-stalled.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (tx_data !== prev_data || tx_valid !== 1'b1)) stab_err++;
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      if (dropped)  dropped_cnt++;
      if (busy)     busy_cnt++;
      if (tx_valid) valid_cnt++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  typedef struct {
    logic [23:0] value;
    logic [47:0] digits;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    got_q.delete();
    dropped_cnt = 0;
    busy_cnt    = 0;
    valid_cnt   = 0;
    stab_err    = 0;
  endtask

  task automatic pulse();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
  endtask

  task automatic run_until_idle(input int budget, input bit rnd);
    int n = 0;
    while ((busy || tx_valid) && n < budget) begin
      if (rnd) tx_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    check("idle_timeout", {31'd0, busy | tx_valid}, 32'd0);
    tx_ready = 1'b1;
  endtask

  task automatic check_line(input string name, input logic [47:0] digits, input int base);
    logic [7:0] exp, act;
    for (int k = 0; k < 12; k++) begin
      if (k == 0)       exp = 8'h43;
      else if (k == 1)  exp = 8'h4E;
      else if (k == 2)  exp = 8'h54;
      else if (k == 3)  exp = 8'h3D;
      else if (k == 10) exp = 8'h0D;
      else if (k == 11) exp = 8'h0A;
      else              exp = digits[47-8*(k-4) -: 8];
      act = (base + k < got_q.size()) ? got_q[base+k] : 8'hxx;
      check($sformatf("%s_byte%0d", name, k), {24'd0, act}, {24'd0, exp});
    end
  endtask

  task automatic wait_size(input int n);
    int c = 0;
    while (got_q.size() < n && c < 100) begin
      step();
      c++;
    end
    check("wait_size_timeout", got_q.size(), n);
  endtask

  initial begin
    vecs[0] = '{24'h00A5F3, 48'h303041354633};
    vecs[1] = '{24'hFFFFFF, 48'h464646464646};
    vecs[2] = '{24'h000000, 48'h303030303030};
    vecs[3] = '{24'h123456, 48'h313233343536};
    vecs[4] = '{24'h89ABCD, 48'h383941424344};

    reset    = 1'b1;
    trigger  = 1'b0;
    value    = 24'h0;
    tx_ready = 1'b1;
    clear_obs();
    #12;
    check("rst_tx_data",  {24'd0, tx_data}, 32'h00);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_busy",     {31'd0, busy}, 32'd0);
    check("rst_dropped",  {31'd0, dropped}, 32'd0);
    step();
    reset = 1'b0;
    step();

    // Table: full-rate lines for several values
    for (int i = 0; i < 5; i++) begin
      clear_obs();
      value = vecs[i].value;
      pulse();
      run_until_idle(100, 1'b0);
      check($sformatf("v%0d_len", i), got_q.size(), 12);
      check_line($sformatf("v%0d", i), vecs[i].digits, 0);
      check($sformatf("v%0d_busy_cycles", i), busy_cnt, 12);
      check($sformatf("v%0d_valid_cycles", i), valid_cnt, 12);
      check($sformatf("v%0d_dropped", i), dropped_cnt, 0);
      step();
    end

    // Random backpressure
    clear_obs();
    value = 24'h00A5F3;
    pulse();
    run_until_idle(400, 1'b1);
    check("rnd_len", got_q.size(), 12);
    check_line("rnd", 48'h303041354633, 0);
    check("rnd_stable", stab_err, 0);
    step();

    // Value change after first byte, edge on byte 5
    clear_obs();
    value = 24'h00A5F3;
    pulse();
    value = 24'hFFFFFF;
    wait_size(4);
    pulse();
    run_until_idle(100, 1'b0);
    check("snap_len", got_q.size(), 12);
    check_line("snap", 48'h303041354633, 0);
    check("snap_dropped", dropped_cnt, 1);
    step();

    // Stall with tx_ready low; edges while stalled are dropped
    clear_obs();
    tx_ready = 1'b0;
    value = 24'h89ABCD;
    pulse();
    repeat (4) step();
    check("stall_data",  {24'd0, tx_data}, 32'h43);
    check("stall_valid", {31'd0, tx_valid}, 32'd1);
    check("stall_count", got_q.size(), 0);
    pulse();
    step();
    pulse();
    step();
    check("stall_dropped", dropped_cnt, 2);
    check("stall_data2", {24'd0, tx_data}, 32'h43);
    tx_ready = 1'b1;
    run_until_idle(100, 1'b0);
    check_line("stall", 48'h383941424344, 0);
    check("stall_stable", stab_err, 0);
    step();

    // Edge in the LF handshake cycle -> back-to-back lines
    clear_obs();
    value = 24'h00A5F3;
    pulse();
    begin
      int c = 0;
      while (!(tx_valid && tx_data == 8'h0A) && c < 50) begin
        step();
        c++;
      end
      check("b2b_lf_timeout", {31'd0, tx_valid && tx_data == 8'h0A}, 32'd1);
    end
    value = 24'h123456;
    pulse();
    run_until_idle(100, 1'b0);
    check("b2b_len", got_q.size(), 24);
    check_line("b2b_l0", 48'h303041354633, 0);
    check_line("b2b_l1", 48'h313233343536, 12);
    check("b2b_valid_cycles", valid_cnt, 24);
    check("b2b_busy_cycles", busy_cnt, 24);
    check("b2b_dropped", dropped_cnt, 0);
    step();

    // Async reset mid DIGITS; trigger held high across release
    clear_obs();
    value = 24'h00A5F3;
    pulse();
    wait_size(6);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
    check("mid_rst_busy",  {31'd0, busy}, 32'd0);
    check("mid_rst_data",  {24'd0, tx_data}, 32'h00);
    trigger = 1'b1;
    step();
    step();
    reset = 1'b0;
    clear_obs();
    repeat (10) step();
    check("held_trig_busy",  busy_cnt, 0);
    check("held_trig_valid", valid_cnt, 0);
    trigger = 1'b0;
    step();
    clear_obs();
    value = 24'h123456;
    pulse();
    run_until_idle(100, 1'b0);
    check("post_rst_len", got_q.size(), 12);
    check_line("post_rst", 48'h313233343536, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
